set_job_sched: RTL and testbench

SET_JOB_SCHED -- requirements
Module: set_job_sched

---
 rtl/set_job_sched_pkg.sv | 20 ++
 rtl/set_job_sched_rr_arb2.sv | 30 +++
 rtl/set_job_sched.sv | 143 ++++++++++++++
 tb/tb_set_job_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_job_sched_pkg.sv
// Shared definitions for the SET job scheduler: FSM states, job-word layout, timeout default.
package set_job_sched_pkg;

  localparam int TIMEOUT_CYC_DEF = 200;

  // Job word is {central, radius, mode}, mode in the LSBs.
  localparam int JOB_W       = 38;
  localparam int MODE_LSB    = 0;
  localparam int MODE_W      = 2;
  localparam int RADIUS_LSB  = 2;
  localparam int RADIUS_W    = 12;
  localparam int CENTRAL_LSB = 14;
  localparam int CENTRAL_W   = 24;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/set_job_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, last-grant pointer updated on upd_i.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
    last_d = last_q;
    if (upd_i) last_d = gnt_o[1];
  end

  // Pointer starts at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/set_job_sched.sv
// Accepts jobs from two requesters, issues one at a time to the SET engine,
// waits for its result or a timeout, and holds the response until consumed.
module set_job_sched
  import set_job_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [JOB_W-1:0]     req0_data,
  input  logic [JOB_W-1:0]     req1_data,
  output logic                 set_en,
  output logic [CENTRAL_W-1:0] set_central,
  output logic [RADIUS_W-1:0]  set_radius,
  output logic [MODE_W-1:0]    set_mode,
  input  logic                 set_busy,
  input  logic                 set_valid,
  input  logic [7:0]           set_candidate,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [7:0]           rsp_candidate,
  output logic                 rsp_timeout,
  output logic [CNT_W-1:0]     jobs_done
);

  localparam int TMR_W = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;

  logic [1:0]           state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [CENTRAL_W-1:0] central_q, central_d;
  logic [RADIUS_W-1:0]  radius_q, radius_d;
  logic [MODE_W-1:0]    mode_q, mode_d;
  logic                 id_q, id_d;
  logic [7:0]           cand_q, cand_d;
  logic                 to_q, to_d;
  logic [CNT_W-1:0]     jobs_q, jobs_d;

  logic [1:0]       gnt;
  logic             idle_ok;
  logic             xfer;
  logic [JOB_W-1:0] job_dat;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_valid),
    .upd_i (xfer),
    .gnt_o (gnt)
  );

  // Only offer a grant when the engine is quiet, so one job is ever in flight.
  assign idle_ok   = (state_q == ST_IDLE) && !set_busy && !set_valid && !rst;
  assign req_ready = idle_ok ? gnt : 2'b00;
  assign xfer      = |req_ready;
  assign job_dat   = req_ready[1] ? req1_data : req0_data;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    central_d = central_q;
    radius_d  = radius_q;
    mode_d    = mode_q;
    id_d      = id_q;
    cand_d    = cand_q;
    to_d      = to_q;
    jobs_d    = jobs_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          central_d = job_dat[CENTRAL_LSB +: CENTRAL_W];
          radius_d  = job_dat[RADIUS_LSB +: RADIUS_W];
          mode_d    = job_dat[MODE_LSB +: MODE_W];
          id_d      = req_ready[1];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A result in the last timeout cycle still wins over the abort.
        if (set_valid) begin
          cand_d  = set_candidate;
          to_d    = 1'b0;
          state_d = ST_RESP;
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          cand_d  = 8'h00;
          to_d    = 1'b1;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          jobs_d  = jobs_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      id_q      <= 1'b0;
      cand_q    <= 8'h00;
      to_q      <= 1'b0;
      jobs_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      central_q <= central_d;
      radius_q  <= radius_d;
      mode_q    <= mode_d;
      id_q      <= id_d;
      cand_q    <= cand_d;
      to_q      <= to_d;
      jobs_q    <= jobs_d;
    end
  end

  assign set_en        = (state_q == ST_ISSUE);
  assign set_central   = central_q;
  assign set_radius    = radius_q;
  assign set_mode      = mode_q;
  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_id        = id_q;
  assign rsp_candidate = cand_q;
  assign rsp_timeout   = to_q;
  assign jobs_done     = jobs_q;

endmodule

// File: tb/tb_set_job_sched.sv
// Directed bench for set_job_sched: arbitration, engine handshake, timeout, backpressure, reset.
module tb_set_job_sched;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [37:0] req0_data, req1_data;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy, set_valid;
  logic [7:0]  set_candidate;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_timeout;
  logic [7:0]  rsp_candidate;
  logic [15:0] jobs_done;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  set_job_sched #(.TIMEOUT_CYC(T), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req0_data     (req0_data),
    .req1_data     (req1_data),
    .set_en        (set_en),
    .set_central   (set_central),
    .set_radius    (set_radius),
    .set_mode      (set_mode),
    .set_busy      (set_busy),
    .set_valid     (set_valid),
    .set_candidate (set_candidate),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_candidate (rsp_candidate),
    .rsp_timeout   (rsp_timeout),
    .jobs_done     (jobs_done)
  );

  // Engine stub result: sum of low operand bytes.
  function automatic logic [7:0] model(input logic [37:0] d);
    return d[21:14] + d[9:2] + {6'b0, d[1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full job from the granted requester; engine answers after lat WAIT cycles.
  task automatic serve(input logic [1:0] exp_gnt, input int lat);
    logic [37:0] d;
    logic [7:0]  c;
    #1;
    chk("grant", {62'b0, req_ready}, {62'b0, exp_gnt});
    d = exp_gnt[1] ? req1_data : req0_data;
    c = model(d);
    tick();
    chk("issue_en", set_en, 1);
    chk("central", set_central, d[37:14]);
    chk("radius", set_radius, d[13:2]);
    chk("mode", set_mode, d[1:0]);
    tick();
    chk("en_pulse", set_en, 0);
    repeat (lat) tick();
    set_valid = 1'b1;
    set_candidate = c;
    tick();
    set_valid = 1'b0;
    set_candidate = 8'h00;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, exp_gnt[1]);
    chk("rsp_cand", rsp_candidate, c);
    chk("rsp_to", rsp_timeout, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b01;
    req0_data = '0;
    req1_data = '0;
    set_busy = 1'b0;
    set_valid = 1'b0;
    set_candidate = 8'h00;
    rsp_ready = 1'b0;
    #1;
    chk("rst_ready", {62'b0, req_ready}, 64'd0);
    repeat (2) tick();
    chk("rst_en", set_en, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_central", set_central, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_cand", rsp_candidate, 0);
    chk("rst_to", rsp_timeout, 0);
    rst = 1'b0;
    req_valid = 2'b00;

    // Spurious set_valid in IDLE blocks ready and causes nothing.
    set_valid = 1'b1;
    set_candidate = 8'hEE;
    req_valid = 2'b01;
    #1;
    chk("spur_ready", {62'b0, req_ready}, 64'd0);
    req_valid = 2'b00;
    repeat (2) tick();
    chk("spur_rspv", rsp_valid, 0);
    chk("spur_en", set_en, 0);
    chk("spur_cand", rsp_candidate, 0);
    set_valid = 1'b0;
    set_candidate = 8'h00;

    // Busy engine blocks ready.
    set_busy = 1'b1;
    req_valid = 2'b01;
    #1;
    chk("busy_ready", {62'b0, req_ready}, 64'd0);
    set_busy = 1'b0;
    req_valid = 2'b00;
    tick();

    // Contention: alternate starting at requester 0.
    req0_data = {24'h000011, 12'h022, 2'd1};
    req1_data = {24'h0000A0, 12'h0B0, 2'd2};
    req_valid = 2'b11;
    serve(2'b01, 1);
    serve(2'b10, 2);
    serve(2'b01, 0);
    serve(2'b10, 3);
    req_valid = 2'b00;
    chk("jobs_rr", jobs_done, 4);

    // Single job from requester 0.
    req0_data = {24'h345678, 12'h444, 2'd0};
    req_valid = 2'b01;
    serve(2'b01, 2);
    req_valid = 2'b00;
    chk("single_cand_ref", model(req0_data), 8'hBC);
    chk("jobs_single", jobs_done, 5);

    // Backpressure with a late set_valid during RESP that must be ignored.
    req_valid = 2'b10;
    #1;
    chk("bp_grant", {62'b0, req_ready}, 64'd2);
    tick();
    req_valid = 2'b00;
    tick();
    set_valid = 1'b1;
    set_candidate = 8'h5A;
    tick();
    set_valid = 1'b1;
    set_candidate = 8'h99;
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_rspv", rsp_valid, 1);
      chk("bp_id", rsp_id, 1);
      chk("bp_cand", rsp_candidate, 8'h5A);
      chk("bp_to", rsp_timeout, 0);
      chk("bp_ready", {62'b0, req_ready}, 64'd0);
      chk("bp_en", set_en, 0);
      tick();
    end
    set_valid = 1'b0;
    set_candidate = 8'h00;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("jobs_bp", jobs_done, 6);

    // Timeout: engine never answers.
    req_valid = 2'b01;
    #1;
    chk("to_grant", {62'b0, req_ready}, 64'd1);
    tick();
    req_valid = 2'b00;
    chk("to_en", set_en, 1);
    n = 0;
    while (!rsp_valid && n < T + 5) begin
      tick();
      n++;
    end
    chk("to_latency", n, T + 1);
    chk("to_flag", rsp_timeout, 1);
    chk("to_cand", rsp_candidate, 0);
    chk("to_id", rsp_id, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("jobs_to", jobs_done, 7);

    // set_valid on the final timeout cycle wins.
    req_valid = 2'b10;
    #1;
    chk("bnd_grant", {62'b0, req_ready}, 64'd2);
    tick();
    req_valid = 2'b00;
    chk("bnd_en", set_en, 1);
    repeat (T) tick();
    chk("bnd_wait", rsp_valid, 0);
    set_valid = 1'b1;
    set_candidate = 8'hC3;
    tick();
    set_valid = 1'b0;
    set_candidate = 8'h00;
    chk("bnd_rspv", rsp_valid, 1);
    chk("bnd_to", rsp_timeout, 0);
    chk("bnd_cand", rsp_candidate, 8'hC3);
    chk("bnd_id", rsp_id, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("jobs_bnd", jobs_done, 8);

    // Reset mid-WAIT abandons the job.
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    repeat (3) tick();
    rst = 1'b1;
    req_valid = 2'b01;
    #1;
    chk("mid_rst_ready", {62'b0, req_ready}, 64'd0);
    tick();
    rst = 1'b0;
    req_valid = 2'b00;
    chk("mid_rspv", rsp_valid, 0);
    chk("mid_jobs", jobs_done, 0);
    chk("mid_central", set_central, 0);
    chk("mid_en", set_en, 0);
    repeat (3) tick();
    chk("mid_stale", rsp_valid, 0);
    req1_data = {24'hABCDEF, 12'h123, 2'd3};
    req_valid = 2'b10;
    serve(2'b10, 1);
    req_valid = 2'b00;
    chk("mid_jobs_after", jobs_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
